// File: rtl/alu_seq.sv
// alu_seq: registered RV32/RV64 ALU with valid/ready handshakes on both sides.
// Basic integer ops complete one cycle after accept. The optional M-extension
// unit (compile with ALU_MULDIV_EN defined) adds an iterative radix-2
// multiply / restoring divide whose result is valid XLEN+2 cycles after accept.
// Without ALU_MULDIV_EN, any fn[4]=1 request completes in one cycle as illegal.
module alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      fn,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_q;
  logic              zero_q;
  logic              illegal_q;

  logic              accept;
  logic              start_md;
  logic              ill_d;
  logic [XLEN-1:0]   res_d;
  logic [SHAMT_W-1:0] shamt;
  logic signed [XLEN-1:0] x_s;
  logic signed [XLEN-1:0] y_s;

  // Conditional two's-complement negate, used for magnitude and sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign x_s      = x;
  assign y_s      = y;
  assign shamt    = y[SHAMT_W-1:0];

  // Single-cycle op decode and result; illegal requests yield zero.
  always_comb begin
    res_d    = '0;
    ill_d    = 1'b0;
    start_md = 1'b0;
    case (fn[2:0])
      3'd0:    res_d = fn[3] ? (x - y) : (x + y);
      3'd1:    res_d = x << shamt;
      3'd2:    res_d = {{(XLEN-1){1'b0}}, (x_s < y_s)};
      3'd3:    res_d = {{(XLEN-1){1'b0}}, (x < y)};
      3'd4:    res_d = x ^ y;
      3'd5:    res_d = fn[3] ? $unsigned(x_s >>> shamt) : (x >> shamt);
      3'd6:    res_d = x | y;
      default: res_d = x & y;
    endcase
    if (fn[3] && fn[2:0] != 3'd0 && fn[2:0] != 3'd5) ill_d = 1'b1;
    if (fn[4]) begin
`ifdef ALU_MULDIV_EN
      start_md = !fn[3];
      ill_d    = fn[3];
`else
      ill_d    = 1'b1;
`endif
    end
    if (ill_d) res_d = '0;
  end

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         f3_q;
  logic [XLEN-1:0]    xin_q;
  logic [XLEN-1:0]    a_q;
  logic               y0_q;
  logic               neg_q;
  logic               negr_q;
  logic [2*XLEN-1:0]  p_q;
  logic [2*XLEN-1:0]  step_d;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN:0]      msum;
  logic [XLEN:0]      rs;
  logic [XLEN:0]      diff;
  logic               x_neg;
  logic               y_neg;
  logic               md_done;
  logic [XLEN-1:0]    md_res;

  // Operand signedness per funct3: MUL/MULH/DIV/REM signed both, MULHSU signs x only.
  always_comb begin
    x_neg = x[XLEN-1] && (fn[2:0] != 3'd3) && (fn[2:0] != 3'd5) && (fn[2:0] != 3'd7);
    y_neg = y[XLEN-1] && (fn[2:0] == 3'd0 || fn[2:0] == 3'd1 ||
                          fn[2:0] == 3'd4 || fn[2:0] == 3'd6);
  end

  // One iteration: p_q holds {acc, multiplier} for mul, {remainder, dividend/quotient} for div.
  always_comb begin
    msum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    rs   = p_q[2*XLEN-1:XLEN-1];
    diff = rs - {1'b0, a_q};
    if (f3_q[2]) step_d = {(diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0]), p_q[XLEN-2:0], ~diff[XLEN]};
    else         step_d = {msum, p_q[XLEN-1:1]};
  end

  // Final sign fix-up and divide corner cases.
  always_comb begin
    prod_fix = neg_if_wide(neg_q, p_q);
    case (f3_q)
      3'd0:    md_res = prod_fix[XLEN-1:0];
      3'd1,
      3'd2,
      3'd3:    md_res = prod_fix[2*XLEN-1:XLEN];
      3'd4:    md_res = y0_q ? '1 : neg_if(neg_q, p_q[XLEN-1:0]);
      3'd5:    md_res = y0_q ? '1 : p_q[XLEN-1:0];
      3'd6:    md_res = y0_q ? xin_q : neg_if(negr_q, p_q[2*XLEN-1:XLEN]);
      default: md_res = y0_q ? xin_q : p_q[2*XLEN-1:XLEN];
    endcase
  end

  assign md_done = (state_q == BUSY) && (cnt_q == CNT_LAST);

  // Iteration counter: XLEN steps then one fix-up cycle.
  always_ff @(posedge clk) begin
    if (rst)                      cnt_q <= '0;
    else if (accept && start_md)  cnt_q <= '0;
    else if (state_q == BUSY)     cnt_q <= cnt_q + 1'b1;
  end

  // Mul/div datapath: load magnitudes on accept, then shift one bit per cycle.
  always_ff @(posedge clk) begin
    if (accept && start_md) begin
      f3_q   <= fn[2:0];
      xin_q  <= x;
      y0_q   <= (y == '0);
      a_q    <= neg_if(y_neg, y);
      p_q    <= {{XLEN{1'b0}}, neg_if(x_neg, x)};
      neg_q  <= x_neg ^ y_neg;
      negr_q <= x_neg;
    end else if (state_q == BUSY && cnt_q != CNT_LAST) begin
      p_q    <= step_d;
    end
  end
`endif

  // Control FSM with registered result outputs, held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (start_md) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_q       <= res_d;
              zero_q      <= (res_d == '0);
              illegal_q   <= ill_d;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
`ifdef ALU_MULDIV_EN
          if (md_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_q       <= md_res;
            zero_q      <= (md_res == '0);
            illegal_q   <= 1'b0;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (XLEN=32). Expectations for fn[4]=1
// vectors depend on whether ALU_MULDIV_EN is defined for the build.
module tb_alu_seq;
  localparam int XLEN = 32;

  localparam logic [4:0] F_ADD = 5'h00, F_SUB = 5'h08, F_SLL = 5'h01, F_SLT = 5'h02;
  localparam logic [4:0] F_SLTU = 5'h03, F_XOR = 5'h04, F_SRL = 5'h05, F_SRA = 5'h0D;
  localparam logic [4:0] F_OR = 5'h06, F_AND = 5'h07, F_BADXOR = 5'h0C;
  localparam logic [4:0] F_MUL = 5'h10, F_MULH = 5'h11, F_MULHSU = 5'h12, F_MULHU = 5'h13;
  localparam logic [4:0] F_DIV = 5'h14, F_DIVU = 5'h15, F_REM = 5'h16, F_REMU = 5'h17;
  localparam logic [4:0] F_BADMD = 5'h18;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [4:0] fn;
  logic [XLEN-1:0] x, y, out;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fn(fn),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .illegal(illegal)
  );

  typedef struct {
    logic [4:0]  fn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] out;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic add_vec(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic z, input logic il);
    vec_t v;
    v.fn = f; v.x = a; v.y = b; v.out = r; v.zero = z; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request at a falling edge once in_ready is high; returns #1 after the accept edge.
  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    fn = f; x = a; y = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles from accept until out_valid is seen (1 = visible the cycle after accept).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int exp_lat;
    logic [31:0] exp_out;
    logic exp_z, exp_il, md, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fn = '0; x = '0; y = '0;

    add_vec(F_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    add_vec(F_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0);
    add_vec(F_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0);
    add_vec(F_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    add_vec(F_SLT,  32'h00000005, 32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0);
    add_vec(F_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    add_vec(F_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    add_vec(F_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0);
    add_vec(F_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0);
    add_vec(F_OR,   32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0);
    add_vec(F_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0);
    add_vec(F_BADXOR, 32'h12345678, 32'h1, 32'h00000000, 1'b1, 1'b1);
    add_vec(F_BADMD,  32'h00000007, 32'h3, 32'h00000000, 1'b1, 1'b1);
    add_vec(F_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
    add_vec(F_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(F_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    add_vec(F_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0);
    add_vec(F_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(F_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(F_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b0);
    add_vec(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);
    add_vec(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    add_vec(F_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0);
    add_vec(F_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out", out, 32'h0);
    check("rst_zero_illegal", {30'b0, zero, illegal}, 32'h2);
    @(negedge clk);
    rst = 1'b0;

    // Table: each vector issued with out_ready=1, checked for value, flags and latency
    for (int i = 0; i < vecs.size(); i++) begin
      md      = vecs[i].fn[4] && !vecs[i].fn[3];
      exp_out = vecs[i].out;
      exp_z   = vecs[i].zero;
      exp_il  = vecs[i].ill;
      exp_lat = 1;
`ifdef ALU_MULDIV_EN
      if (md) exp_lat = XLEN + 2;
`else
      if (md) begin
        exp_out = 32'h0;
        exp_z   = 1'b1;
        exp_il  = 1'b1;
      end
`endif
      issue(vecs[i].fn, vecs[i].x, vecs[i].y);
      wait_result(lat);
      check($sformatf("v%0d_fn%02h_out", i, vecs[i].fn), out, exp_out);
      check($sformatf("v%0d_fn%02h_zero_illegal", i, vecs[i].fn), {30'b0, zero, illegal},
            {30'b0, exp_z, exp_il});
      check($sformatf("v%0d_fn%02h_latency", i, vecs[i].fn), lat, exp_lat);
    end
    repeat (2) @(posedge clk);

    // Back-to-back SLT then SLTU with out_ready=1: in_ready stays high throughout
    @(negedge clk);
    check("b2b_ready_first", {31'b0, in_ready}, 32'h1);
    fn = F_SLT; x = 32'hFFFFFFFF; y = 32'h1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_slt_out", out, 32'h1);
    check("b2b_slt_valid", {31'b0, out_valid}, 32'h1);
    fn = F_SLTU;
    check("b2b_ready_second", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("b2b_sltu_out", out, 32'h0);
    check("b2b_sltu_valid", {31'b0, out_valid}, 32'h1);
    check("b2b_ready_after", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Output stall: XOR result held for 3 cycles while a pending ADD waits
    out_ready = 1'b0;
    issue(F_XOR, 32'hAAAA5555, 32'h0000FFFF);
    check("hold_first", out, 32'hAAAAAAAA);
    @(negedge clk);
    fn = F_ADD; x = 32'h1; y = 32'h1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_c%0d_out", c), out, 32'hAAAAAAAA);
      check($sformatf("hold_c%0d_valid_ready", c), {30'b0, out_valid, in_ready}, 32'h2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("hold_release_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("hold_next_out", out, 32'h2);
    repeat (2) @(posedge clk);

`ifdef ALU_MULDIV_EN
    // Reset during the tenth BUSY cycle aborts the multiply
    issue(F_MUL, 32'h7, 32'h3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid_ready", {30'b0, out_valid, in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", {31'b0, seen}, 32'h0);
    issue(F_MUL, 32'h6, 32'h7);
    wait_result(lat);
    check("abort_then_mul", out, 32'h2A);
`else
    // Reset with a held result discards it
    out_ready = 1'b0;
    issue(F_ADD, 32'h3, 32'h4);
    check("rst_hold_out", out, 32'h7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_valid_ready", {30'b0, out_valid, in_ready}, 32'h1);
    check("rst_hold_cleared", {out[29:0], zero, illegal}, 32'h2);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_hold_no_result", {31'b0, seen}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
